// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage (PC, imem address, IF/ID register); FETCH_PERF_CNT_EN adds saturating fetch/flush counters
module fetch_stage #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                pc_src,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_address,
    input  logic [31:0]         imem_instruction,
    output logic [31:0]         if_id_instruction,
    output logic [PC_WIDTH-1:0] if_id_pc_plus4,
    output logic                if_id_valid,
    output logic [31:0]         fetch_count,
    output logic [31:0]         flush_count
);
    localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);
    logic [PC_WIDTH-1:0] pc, pc_plus4, pc_next;
    assign pc_plus4     = pc + PC_STEP;
    assign imem_address = pc;
    // word alignment is enforced on every PC load, so pc[1:0] stays 00
    always_comb pc_next = (pc_src ? branch_target : pc_plus4) & ALIGN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_PC & ALIGN;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
        end else if (!stall) begin
            pc                <= pc_next;
            if_id_instruction <= flush ? '0 : imem_instruction;
            if_id_pc_plus4    <= flush ? '0 : pc_plus4;
            if_id_valid       <= !flush;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else if (!stall) begin
            if (!flush && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (flush && flush_count != '1) flush_count <= flush_count + 32'd1;
        end
    end
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif
endmodule
